// File: rtl/axi_pmu_snapshot_reader.sv
`default_nettype none
// ============================================================================
// Module   : axi_pmu_snapshot_reader
// Purpose  : AXI4-Lite master that reads N_COUNTERS consecutive PMU counter
//            registers on a start pulse and streams each value out on a
//            valid/ready port. It can optionally write CLEAR_VALUE to the PMU
//            configuration register after the sweep. Only one AXI transaction
//            is outstanding at any time, and no bursts are issued.
// Ports    : M_AXI_ACLK_i / M_AXI_ARESET_i  - clock, synchronous active-high reset
//            start_i, clear_i               - sweep request and clear-after-sweep
//            busy_o, done_o, err_o          - sweep status
//            data_o, idx_o, data_valid_o,
//            data_ready_i                   - counter value stream
//            M_AXI_*                        - AXI4-Lite master channels
// Revision : 1.0 - initial release
// ============================================================================
module axi_pmu_snapshot_reader #(
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_M_AXI_ADDR_WIDTH = 7,
   parameter int N_COUNTERS         = 16,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] CNT_BASE_ADDR = 'h0,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] CONF_ADDR     = 'h40,
   parameter logic [C_M_AXI_DATA_WIDTH-1:0] CLEAR_VALUE   = 'h2,
   localparam int IDX_W = (N_COUNTERS > 1) ? $clog2(N_COUNTERS) : 1
) (
   input  logic                            M_AXI_ACLK_i,
   input  logic                            M_AXI_ARESET_i,
   input  logic                            start_i,
   input  logic                            clear_i,
   output logic                            busy_o,
   output logic                            done_o,
   output logic                            err_o,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   data_o,
   output logic [IDX_W-1:0]                idx_o,
   output logic                            data_valid_o,
   input  logic                            data_ready_i,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR_o,
   output logic                            M_AXI_AWVALID_o,
   input  logic                            M_AXI_AWREADY_i,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA_o,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB_o,
   output logic                            M_AXI_WVALID_o,
   input  logic                            M_AXI_WREADY_i,
   input  logic [1:0]                      M_AXI_BRESP_i,
   input  logic                            M_AXI_BVALID_i,
   output logic                            M_AXI_BREADY_o,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR_o,
   output logic                            M_AXI_ARVALID_o,
   input  logic                            M_AXI_ARREADY_i,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA_i,
   input  logic [1:0]                      M_AXI_RRESP_i,
   input  logic                            M_AXI_RVALID_i,
   output logic                            M_AXI_RREADY_o
);

   localparam logic [C_M_AXI_ADDR_WIDTH-1:0] C_STRIDE   = C_M_AXI_ADDR_WIDTH'(C_M_AXI_DATA_WIDTH / 8);
   localparam logic [IDX_W-1:0]              C_LAST_IDX = IDX_W'(N_COUNTERS - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AR   = 3'd1,
      S_R    = 3'd2,
      S_OUT  = 3'd3,
      S_WR   = 3'd4,
      S_B    = 3'd5,
      S_DONE = 3'd6
   } state_t;

   state_t                          state_q, state_d;
   logic [IDX_W-1:0]                idx_q, idx_d;          // counter being read
   logic [IDX_W-1:0]                idx_out_q, idx_out_d;  // index presented on idx_o
   logic                            clear_q, clear_d;
   logic                            err_q, err_d;
   logic [C_M_AXI_DATA_WIDTH-1:0]   data_q, data_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                            aw_done_q, aw_done_d;  // AW handshake already taken
   logic                            w_done_q, w_done_d;    // W handshake already taken
   logic                            aw_fin, w_fin;

   always_ff @(posedge M_AXI_ACLK_i) begin
      if (M_AXI_ARESET_i) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         idx_out_q <= '0;
         clear_q   <= 1'b0;
         err_q     <= 1'b0;
         data_q    <= '0;
         araddr_q  <= '0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         idx_out_q <= idx_out_d;
         clear_q   <= clear_d;
         err_q     <= err_d;
         data_q    <= data_d;
         araddr_q  <= araddr_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   // A channel counts as finished once it has handshaken in this or an earlier cycle.
   assign aw_fin = aw_done_q | M_AXI_AWREADY_i;
   assign w_fin  = w_done_q  | M_AXI_WREADY_i;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      idx_out_d = idx_out_q;
      clear_d   = clear_q;
      err_d     = err_q;
      data_d    = data_q;
      araddr_d  = araddr_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               clear_d  = clear_i;
               idx_d    = '0;
               err_d    = 1'b0;
               araddr_d = CNT_BASE_ADDR;
               state_d  = S_AR;
            end
         end
         S_AR: begin
            if (M_AXI_ARREADY_i) begin
               state_d = S_R;
            end
         end
         S_R: begin
            if (M_AXI_RVALID_i) begin
               data_d    = M_AXI_RDATA_i;
               idx_out_d = idx_q;
               if (M_AXI_RRESP_i != 2'b00) begin
                  err_d = 1'b1;
               end
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            if (data_ready_i) begin
               if (idx_q != C_LAST_IDX) begin
                  idx_d    = idx_q + 1'b1;
                  // Address of the next counter is prepared here so ARADDR is
                  // already stable in the first AR cycle.
                  araddr_d = CNT_BASE_ADDR +
                             C_M_AXI_ADDR_WIDTH'(idx_q + 1'b1) * C_STRIDE;
                  state_d  = S_AR;
               end else if (clear_q) begin
                  awaddr_d  = CONF_ADDR;
                  wdata_d   = CLEAR_VALUE;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
                  state_d   = S_WR;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_WR: begin
            if (M_AXI_AWREADY_i) begin
               aw_done_d = 1'b1;
            end
            if (M_AXI_WREADY_i) begin
               w_done_d = 1'b1;
            end
            if (aw_fin && w_fin) begin
               state_d = S_B;
            end
         end
         S_B: begin
            if (M_AXI_BVALID_i) begin
               if (M_AXI_BRESP_i != 2'b00) begin
                  err_d = 1'b1;
               end
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // All handshake outputs are pure decodes of registered state, so no VALID
   // ever depends on a READY input.
   assign M_AXI_ARVALID_o = (state_q == S_AR);
   assign M_AXI_RREADY_o  = (state_q == S_R);
   assign M_AXI_AWVALID_o = (state_q == S_WR) && !aw_done_q;
   assign M_AXI_WVALID_o  = (state_q == S_WR) && !w_done_q;
   assign M_AXI_BREADY_o  = (state_q == S_B);
   assign data_valid_o    = (state_q == S_OUT);
   assign done_o          = (state_q == S_DONE);
   assign busy_o          = (state_q != S_IDLE) && (state_q != S_DONE);

   assign M_AXI_ARADDR_o  = araddr_q;
   assign M_AXI_AWADDR_o  = awaddr_q;
   assign M_AXI_WDATA_o   = wdata_q;
   assign M_AXI_WSTRB_o   = '1;
   assign data_o          = data_q;
   assign idx_o           = idx_out_q;
   assign err_o           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_pmu_snapshot_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_pmu_snapshot_reader
// Purpose  : Self-checking bench for axi_pmu_snapshot_reader. A behavioural
//            AXI-Lite slave with per-sweep latency knobs sits on the master
//            port, and a sink with optional stalls sits on the stream port.
//            Each sweep is compared against the values the reader should
//            return: the counter list, the address list, the clear write and
//            the error flag.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_pmu_snapshot_reader;
   localparam int DW = 32;
   localparam int AW = 7;
   localparam int N  = 16;
   localparam int IW = 4;

   typedef struct {
      bit clear;
      int ar_lat, r_lat, aw_lat, w_lat, b_lat;
      int bad_idx;       // counter whose RRESP is SLVERR, -1 = none
      bit bresp_bad;
      int stall_idx, stall_len;
      bit rnd_ready;
      bit seq_data;      // counter i reads as i+100, otherwise random
      bit exp_err;
      int exp_busy;      // busy_o cycles per sweep, -1 = not checked
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic start_i = 1'b0, clear_i = 1'b0, data_ready_i = 1'b0;
   logic arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
   logic [DW-1:0] rdata = '0;
   logic [1:0] rresp = 2'b00, bresp = 2'b00;

   logic busy_o, done_o, err_o, data_valid_o;
   logic [DW-1:0] data_o;
   logic [IW-1:0] idx_o;
   logic [AW-1:0] awaddr, araddr;
   logic awvalid, wvalid, bready, arvalid, rready;
   logic [DW-1:0] wdata;
   logic [DW/8-1:0] wstrb;

   axi_pmu_snapshot_reader dut (
      .M_AXI_ACLK_i    (clk),
      .M_AXI_ARESET_i  (rst),
      .start_i         (start_i),
      .clear_i         (clear_i),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .err_o           (err_o),
      .data_o          (data_o),
      .idx_o           (idx_o),
      .data_valid_o    (data_valid_o),
      .data_ready_i    (data_ready_i),
      .M_AXI_AWADDR_o  (awaddr),
      .M_AXI_AWVALID_o (awvalid),
      .M_AXI_AWREADY_i (awready),
      .M_AXI_WDATA_o   (wdata),
      .M_AXI_WSTRB_o   (wstrb),
      .M_AXI_WVALID_o  (wvalid),
      .M_AXI_WREADY_i  (wready),
      .M_AXI_BRESP_i   (bresp),
      .M_AXI_BVALID_i  (bvalid),
      .M_AXI_BREADY_o  (bready),
      .M_AXI_ARADDR_o  (araddr),
      .M_AXI_ARVALID_o (arvalid),
      .M_AXI_ARREADY_i (arready),
      .M_AXI_RDATA_i   (rdata),
      .M_AXI_RRESP_i   (rresp),
      .M_AXI_RVALID_i  (rvalid),
      .M_AXI_RREADY_o  (rready)
   );

   // slave / sink knobs
   int k_ar_lat = 0, k_r_lat = 0, k_aw_lat = 0, k_w_lat = 0, k_b_lat = 0;
   int k_bad_idx = -1, k_stall_idx = -1, k_stall_len = 0;
   bit k_bresp_bad = 0, k_rnd_ready = 0;
   logic [DW-1:0] mem [N];

   // observations
   logic [DW-1:0] q_data[$];
   int            q_idx[$];
   logic [AW-1:0] q_araddr[$];
   logic [AW-1:0] q_awaddr[$];
   logic [DW-1:0] q_wdata[$];
   int done_cnt = 0, busy_cyc = 0, viol = 0;
   logic err_at_done = 1'b0;

   // slave / sink state
   bit pend_r = 0, pend_b = 0, aw_got = 0, w_got = 0;
   int ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0, stall_c = 0;
   logic [AW-1:0] rd_addr = '0;
   bit p_ar = 0, p_aw = 0, p_w = 0, p_out = 0;
   logic [AW-1:0] p_araddr = '0;
   logic [DW-1:0] p_data = '0;
   logic [IW-1:0] p_idx = '0;

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   // Slave, sink and monitor. Everything is decided on the falling edge, so the
   // handshakes recorded here are the ones the DUT sees at the next rising edge.
   always @(negedge clk) begin
      if (rst) begin
         arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
         data_ready_i = 0;
         pend_r = 0; pend_b = 0; aw_got = 0; w_got = 0;
         ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
         p_ar = 0; p_aw = 0; p_w = 0; p_out = 0;
      end else begin
         // signals left waiting last cycle must still be there, unchanged
         if (p_ar && !(arvalid && araddr == p_araddr)) viol++;
         if (p_out && !(data_valid_o && data_o == p_data && idx_o == p_idx)) viol++;
         if (p_aw && !(awvalid && awaddr == 7'h40)) viol++;
         if (p_w && !(wvalid && wdata == 32'h2)) viol++;
         if (arvalid && data_valid_o) viol++;

         rvalid = 0;
         if (pend_r) begin
            if (r_c >= k_r_lat) begin
               rvalid = 1;
               rdata  = mem[(int'(rd_addr) / 4) % N];
               rresp  = (int'(rd_addr) / 4 == k_bad_idx) ? 2'b10 : 2'b00;
            end else r_c++;
         end
         if (rvalid && rready) pend_r = 0;

         bvalid = 0;
         if (pend_b) begin
            if (b_c >= k_b_lat) begin
               bvalid = 1;
               bresp  = k_bresp_bad ? 2'b10 : 2'b00;
            end else b_c++;
         end
         if (bvalid && bready) pend_b = 0;

         arready = 0;
         if (arvalid) begin
            if (ar_c >= k_ar_lat) begin
               arready = 1; ar_c = 0;
               q_araddr.push_back(araddr);
               pend_r = 1; r_c = 0; rd_addr = araddr;
            end else ar_c++;
         end

         awready = 0;
         if (awvalid) begin
            if (aw_c >= k_aw_lat) begin
               awready = 1; aw_c = 0; aw_got = 1;
               q_awaddr.push_back(awaddr);
            end else aw_c++;
         end
         wready = 0;
         if (wvalid) begin
            if (w_c >= k_w_lat) begin
               wready = 1; w_c = 0; w_got = 1;
               q_wdata.push_back(wdata);
            end else w_c++;
         end
         if (aw_got && w_got) begin
            pend_b = 1; b_c = 0; aw_got = 0; w_got = 0;
         end

         data_ready_i = 0;
         if (data_valid_o) begin
            if (int'(idx_o) == k_stall_idx && stall_c < k_stall_len) stall_c++;
            else data_ready_i = k_rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (data_ready_i) begin
               q_idx.push_back(int'(idx_o));
               q_data.push_back(data_o);
            end
         end

         if (done_o) begin
            done_cnt++;
            err_at_done = err_o;
         end
         if (busy_o) busy_cyc++;

         p_ar = arvalid && !arready;   p_araddr = araddr;
         p_aw = awvalid && !awready;
         p_w  = wvalid && !wready;
         p_out = data_valid_o && !data_ready_i; p_data = data_o; p_idx = idx_o;
      end
   end

   task automatic setup(input vec_t v);
      k_ar_lat = v.ar_lat; k_r_lat = v.r_lat; k_aw_lat = v.aw_lat;
      k_w_lat = v.w_lat;   k_b_lat = v.b_lat; k_bad_idx = v.bad_idx;
      k_bresp_bad = v.bresp_bad; k_stall_idx = v.stall_idx;
      k_stall_len = v.stall_len; k_rnd_ready = v.rnd_ready;
      for (int i = 0; i < N; i++) mem[i] = v.seq_data ? DW'(i + 100) : $urandom;
      q_data.delete(); q_idx.delete(); q_araddr.delete();
      q_awaddr.delete(); q_wdata.delete();
      done_cnt = 0; busy_cyc = 0; viol = 0; stall_c = 0;
   endtask

   task automatic wait_done();
      int t = 0;
      while (done_cnt == 0 && t < 5000) begin
         @(negedge clk);
         t++;
      end
      chk("done_seen", 64'(done_cnt > 0), 64'd1);
   endtask

   task automatic run_sweep(input vec_t v);
      @(negedge clk);
      setup(v);
      start_i = 1'b1; clear_i = v.clear;
      @(negedge clk);
      start_i = 1'b0; clear_i = 1'b0;
      chk("err_cleared_on_start", 64'(err_o), 64'd0);
      wait_done();
      repeat (3) @(negedge clk);
      chk("done_pulses", 64'(done_cnt), 64'd1);
      chk("n_out", 64'(q_data.size()), 64'(N));
      for (int i = 0; i < N && i < q_data.size(); i++)
         chk($sformatf("out[%0d] idx/data", i), {32'(q_idx[i]), q_data[i]},
             {32'(i), mem[i]});
      chk("n_ar", 64'(q_araddr.size()), 64'(N));
      for (int i = 0; i < N && i < q_araddr.size(); i++)
         chk($sformatf("araddr[%0d]", i), 64'(q_araddr[i]), 64'(4 * i));
      chk("n_aw", 64'(q_awaddr.size()), 64'(v.clear));
      chk("n_w", 64'(q_wdata.size()), 64'(v.clear));
      if (q_awaddr.size() > 0) chk("awaddr", 64'(q_awaddr[0]), 64'h40);
      if (q_wdata.size() > 0) chk("wdata", 64'(q_wdata[0]), 64'h2);
      chk("err_at_done", 64'(err_at_done), 64'(v.exp_err));
      chk("stability_violations", 64'(viol), 64'd0);
      if (v.exp_busy >= 0) chk("busy_cycles", 64'(busy_cyc), 64'(v.exp_busy));
      chk("idle_after", 64'(busy_o), 64'd0);
   endtask

   vec_t vecs[$];
   vec_t rv;
   int n_ar_before;

   initial begin
      //           clr ar r  aw w  b  bad bb stl len rnd seq err busy
      vecs.push_back('{0, 0, 0, 0, 0, 0, -1, 0, -1, 0,  0, 1, 0, 48});
      vecs.push_back('{0, 3, 5, 0, 0, 0, -1, 0, -1, 0,  0, 1, 0, -1});
      vecs.push_back('{0, 0, 0, 0, 0, 0, -1, 0,  4, 10, 0, 0, 0, 58});
      vecs.push_back('{1, 0, 0, 3, 0, 2, -1, 0, -1, 0,  0, 0, 0, 55});
      vecs.push_back('{1, 0, 0, 0, 4, 0, -1, 0, -1, 0,  0, 0, 0, -1});
      vecs.push_back('{0, 0, 0, 0, 0, 0,  7, 0, -1, 0,  0, 0, 1, 48});
      vecs.push_back('{1, 0, 0, 0, 0, 0, -1, 1, -1, 0,  0, 0, 1, 50});
      vecs.push_back('{1, 1, 2, 2, 2, 1,  0, 0, 15, 3,  1, 0, 1, -1});

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_ctrl", {arvalid, rready, awvalid, wvalid, bready,
                       data_valid_o, busy_o, done_o, err_o}, 64'd0);
      chk("rst_data", 64'(data_o), 64'd0);
      chk("rst_idx", 64'(idx_o), 64'd0);
      chk("rst_addr", {araddr, awaddr}, 64'd0);
      chk("rst_wstrb", 64'(wstrb), 64'hF);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      foreach (vecs[i]) run_sweep(vecs[i]);

      // randomized sweeps; expected error comes from the response model
      for (int n = 0; n < 8; n++) begin
         rv.clear     = 1'($urandom_range(0, 1));
         rv.ar_lat    = $urandom_range(0, 4);
         rv.r_lat     = $urandom_range(0, 4);
         rv.aw_lat    = $urandom_range(0, 4);
         rv.w_lat     = $urandom_range(0, 4);
         rv.b_lat     = $urandom_range(0, 4);
         rv.bad_idx   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, N - 1) : -1;
         rv.bresp_bad = 1'($urandom_range(0, 1));
         rv.stall_idx = $urandom_range(0, N - 1);
         rv.stall_len = $urandom_range(0, 6);
         rv.rnd_ready = 1'b1;
         rv.seq_data  = 1'b0;
         rv.exp_err   = (rv.bad_idx >= 0) || (rv.clear && rv.bresp_bad);
         rv.exp_busy  = -1;
         run_sweep(rv);
      end

      // start pulsed while busy is ignored
      @(negedge clk);
      setup(vecs[0]);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (10) @(negedge clk);
      start_i = 1'b1; clear_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0; clear_i = 1'b0;
      wait_done();
      repeat (30) @(negedge clk);
      chk("busy_start_done_cnt", 64'(done_cnt), 64'd1);
      chk("busy_start_n_out", 64'(q_data.size()), 64'(N));
      chk("busy_start_n_ar", 64'(q_araddr.size()), 64'(N));
      chk("busy_start_n_aw", 64'(q_awaddr.size()), 64'd0);

      // reset while waiting for read data
      rv = vecs[0];
      rv.r_lat = 8;
      @(negedge clk);
      setup(rv);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (12) @(negedge clk);
      begin
         int t = 0;
         while (!rready && t < 200) begin
            @(negedge clk);
            t++;
         end
      end
      chk("reached_R", 64'(rready), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_ctrl", {arvalid, rready, awvalid, wvalid, bready,
                          data_valid_o, busy_o, done_o, err_o}, 64'd0);
      chk("midrst_data", {32'(idx_o), data_o}, 64'd0);
      rst = 1'b0;
      n_ar_before = q_araddr.size();
      done_cnt = 0;
      repeat (20) @(negedge clk);
      chk("post_rst_no_ar", 64'(q_araddr.size()), 64'(n_ar_before));
      chk("post_rst_idle", {busy_o, 32'(done_cnt)}, 64'd0);

      run_sweep(vecs[0]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
